// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: assembles DATA_W data bits LSB first, checks the
// trailing parity bit (even/odd per frame) and keeps a saturating error count.
module parity_frame_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int BCNT_W = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              odd_mode,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              clr_count,
  output logic              busy,
  output logic              frame_done,
  output logic              parity_err,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                perr_q, perr_d;
  logic [CNT_W-1:0]    errc_q, errc_d;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    errc_d  = errc_q;

    unique case (state_q)
      IDLE: begin
        // Seeding the accumulator with odd_mode is how the mode is latched.
        if (start) begin
          state_d = DATA;
          bcnt_d  = '0;
          acc_d   = odd_mode;
          busy_d  = 1'b1;
        end
      end
      DATA: begin
        if (bit_valid) begin
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (bcnt_q == BCNT_W'(i)) shift_d[i] = bit_in;
          end
          acc_d  = acc_q ^ bit_in;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_W'(DATA_W - 1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (bit_valid) begin
          done_d  = 1'b1;
          perr_d  = acc_q ^ bit_in;
          data_d  = shift_q;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_count) begin
      errc_d = '0;
    end else if (done_d && perr_d && !(&errc_q)) begin
      errc_d = errc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      errc_q  <= errc_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign parity_err = perr_q;
  assign data_out   = data_q;
  assign err_count  = errc_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized bench for parity_frame_checker: frames are scored by a frame-level
// model (popcount parity, saturating counter) and checked cycle by cycle.
module tb_parity_frame_checker;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, start, odd_mode, bit_in, bit_valid, clr_count;
  logic              busy, frame_done, parity_err;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  err_count;

  parity_frame_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .odd_mode(odd_mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .clr_count(clr_count), .busy(busy),
    .frame_done(frame_done), .parity_err(parity_err), .data_out(data_out),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_cnt  = 0;
  logic [7:0]  exp_data = '0;
  logic        exp_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_held();
    check("held_data", 32'(data_out), 32'(exp_data));
    check("held_perr", 32'(parity_err), 32'(exp_err));
    check("held_cnt", 32'(err_count), exp_cnt);
  endtask

  task automatic busy_cycle(input logic b, input logic v, input logic noise, input logic odd);
    bit_valid = v;
    bit_in    = b;
    start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    odd_mode  = noise ? 1'($urandom_range(0, 1)) : odd;
    @(negedge clk);
    check("busy", 32'(busy), 1);
    check("no_done", 32'(frame_done), 0);
    check_held();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic odd, input logic par,
                            input int stall_at, input logic rstall, input logic noise,
                            input logic clr_end);
    int unsigned ones;
    logic        e;
    start     = 1'b1;
    odd_mode  = odd;
    bit_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bit_in    = 1'($urandom_range(0, 1));
    clr_count = 1'b0;
    @(negedge clk);
    check("start_busy", 32'(busy), 1);
    check("start_no_done", 32'(frame_done), 0);
    check_held();
    for (int i = 0; i < DATA_W; i++) begin
      if (i == stall_at) begin
        busy_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, odd);
        start = 1'b1;
        busy_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, odd);
        busy_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, odd);
      end
      if (rstall && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) busy_cycle(1'($urandom_range(0, 1)), 1'b0, noise, odd);
      busy_cycle(data[i], 1'b1, noise, odd);
    end
    if (rstall && $urandom_range(0, 3) == 0)
      busy_cycle(1'($urandom_range(0, 1)), 1'b0, noise, odd);
    start     = 1'b0;
    bit_valid = 1'b1;
    bit_in    = par;
    clr_count = clr_end;
    ones = $countones({data, par});
    e    = odd ? (ones % 2 == 0) : (ones % 2 == 1);
    if (clr_end) exp_cnt = 0;
    else if (e && exp_cnt < CMAX) exp_cnt++;
    exp_data = data;
    exp_err  = e;
    @(negedge clk);
    clr_count = 1'b0;
    bit_valid = 1'b0;
    check("done", 32'(frame_done), 1);
    check("done_busy", 32'(busy), 0);
    check_held();
  endtask

  task automatic idle(input int n, input logic clr);
    for (int k = 0; k < n; k++) begin
      start     = 1'b0;
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      odd_mode  = 1'($urandom_range(0, 1));
      clr_count = clr && (k == 0);
      if (clr_count) exp_cnt = 0;
      @(negedge clk);
      clr_count = 1'b0;
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(frame_done), 0);
      check_held();
    end
  endtask

  task automatic check_all_zero();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_perr", 32'(parity_err), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_cnt", 32'(err_count), 0);
  endtask

  initial begin
    int          sat_tab [5] = '{1, 2, 3, 3, 3};
    logic [7:0]  d;
    longint      t0;
    rst = 1'b1; start = 1'b0; odd_mode = 1'b0; bit_in = 1'b0;
    bit_valid = 1'b0; clr_count = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    idle(2, 1'b0);

    send_frame(8'hA5, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    check("odd_a5_p0_err", 32'(parity_err), 1);
    send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    check("odd_a5_p1_cnt", 32'(err_count), 1);

    send_frame(8'h01, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    idle(1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      send_frame(d, 1'b0, ~(^d), -1, 1'b0, 1'b0, 1'b0);
      check("sat_seq", 32'(err_count), sat_tab[k]);
    end
    d = 8'($urandom);
    send_frame(d, 1'b0, ~(^d), -1, 1'b0, 1'b0, 1'b1);
    check("clr_prio", 32'(err_count), 0);
    send_frame(8'h07, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    start = 1'b1; odd_mode = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) busy_cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    exp_cnt = 0; exp_data = '0; exp_err = 1'b0;
    check_all_zero();
    @(negedge clk);
    rst = 1'b0;
    idle(1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    send_frame(8'h12, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    t0 = longint'($time);
    send_frame(8'hFF, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    check("b2b_lat", 32'((longint'($time) - t0) / 10), 10);
    check("b2b_perr", 32'(parity_err), 1);

    for (int k = 0; k < 150; k++) begin
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1,
                 1'b1, 1'b1, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
